lfsr_prng: RTL and testbench
============================

// Module: lfsr_prng
// PURPOSE
//  Parametrised pseudo-random generator: WIDTH-bit LFSR with selectable Fibonacci/Galois form,
//  runtime seed load, step enable, zero-state (lock-up) protection and period measurement.
//  Drives test-pattern and scrambler logic in the memory subsystem; supersedes the fixed 4-bit LFSR.
// PARAMETERS
//  WIDTH   8       register width, 3..32
//  TAPS    8'hB8   feedback mask, bit i set = tap on x[i]; 8'hB8 = x^8+x^6+x^5+x^4+1 (maximal)
//  MODE    0       0 = Fibonacci (shift left), 1 = Galois (shift right)
//  SEED    1       reset value of x; must be nonzero (0 is treated as 1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  en          in   1      advance one step this cycle
//  load        in   1      load seed_in this cycle (priority over en)
//  seed_in     in   WIDTH  runtime seed
//  x           out  WIDTH  current LFSR state (registered)
//  bit_out     out  1      serial output = x[WIDTH-1] (MODE 0) or x[0] (MODE 1), combinational from x
//  wrap        out  1      1-cycle pulse: state just returned to the active seed
//  period      out  32     step count of last completed cycle, 0 until first wrap
//  lockup      out  1      1-cycle pulse: zero state detected and corrected
// BEHAVIOUR
//  - Reset: x=SEED (1 if SEED==0), active seed=same, step counter=0, period=0, wrap=0, lockup=0.
//  - Priority per cycle: rst > load > en > hold. Pulses (wrap, lockup) are 0 unless set that cycle.
//  - load: x<=seed_in, active seed<=seed_in, step counter<=0; wrap not asserted. seed_in==0 ->
//    x<=1, active seed<=1, lockup=1 next cycle.
//  - en (no load), 1-cycle latency:
//    MODE 0: fb = ^(x & TAPS); x <= {x[WIDTH-2:0], fb}.
//    MODE 1: x <= (x >> 1) ^ (x[0] ? TAPS : 0).
//    step counter += 1 (32-bit, saturates at 2^32-1, no wrap-around).
//  - Wrap: if next x == active seed on an en step: wrap=1 same edge as the update,
//    period<=step counter+1, step counter<=0. period holds until next wrap or rst; load leaves it.
//  - Lock-up: if x==0 (non-maximal TAPS or fault) when en=1: x<=active seed, lockup=1, counter<=0,
//    no wrap. Unreachable with maximal TAPS and nonzero seed.
//  - en=0, load=0: everything holds; pulses deassert.
//  - rst mid-sequence discards all state, including period.
//  - load and en together: load wins, no step taken, counter=0.
//  - TAPS bits >= WIDTH ignored (masked).
// STRUCTURE
//  - Shared include lfsr_defs.vh: MODE_FIB=0, MODE_GAL=1, default maximal tap masks for
//    WIDTH 4 (4'hC), 8 (8'hB8), 16 (16'hB400), 32 (32'h80200003).
//  - Sub-module lfsr_next (pure combinational: x, TAPS, MODE -> next state), reusable by
//    scramblers; lfsr_prng holds registers, seed, counter and pulse logic.
// TESTING (bench built with WIDTH=4, TAPS=4'hC, SEED=1 unless noted)
//  1 MODE=0, rst 2 cycles then en=1: x = 1,2,4,9,3,6,D,...; wrap on step 15, x==1, period=15.
//  2 MODE=1, same stimulus: x = 1,C,6,3,D,A,...; wrap on step 15, period=15.
//  3 en toggled 1-0-1 with gaps: x and counter hold while en=0; period still 15 at wrap.
//  4 load seed_in=4'h9 with en=1 same cycle: next x=9, no step, no wrap; 15 further steps -> wrap at x=9.
//  5 load seed_in=0: next x=1, lockup=1 one cycle; TAPS=4'h0 build, load 4'h8, step 4x -> x=0 ->
//    next en gives x=8, lockup=1.
//  6 rst asserted mid-sequence after a wrap: next cycle x=1, period=0, wrap=lockup=0.

Source files
------------

// File: rtl/lfsr_prng_pkg.sv
// Shared constants for the LFSR family: form selectors and default maximal tap masks.
// Other blocks that need the same feedback polynomials should import this package.
package lfsr_prng_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    // Widths without a tabulated polynomial fall back to the 8-bit mask; callers should override.
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            4:       return {28'd0, TAPS_W4};
            16:      return {16'd0, TAPS_W16};
            32:      return TAPS_W32;
            default: return {24'd0, TAPS_W8};
        endcase
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Pure combinational next-state function of a WIDTH-bit LFSR, Fibonacci or Galois form.
// Kept free of state so scramblers can reuse the exact same polynomial stepping.
module lfsr_next
    import lfsr_prng_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h0000_00B8,
    parameter int          MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] nxt
);

    // Tap bits at or above WIDTH have no register to attach to and are dropped.
    localparam logic [WIDTH-1:0] TAP_M = TAPS[WIDTH-1:0];

    generate
        if (MODE == MODE_FIB) begin : g_fib
            assign nxt = {x[WIDTH-2:0], ^(x & TAP_M)};
        end else begin : g_gal
            assign nxt = (x >> 1) ^ (x[0] ? TAP_M : '0);
        end
    endgenerate

endmodule

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random generator with runtime seed load, zero-state recovery and
// measurement of the step count between returns to the active seed.
module lfsr_prng
    import lfsr_prng_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [31:0] TAPS  = default_taps(WIDTH),
    parameter int          MODE  = MODE_FIB,
    parameter logic [31:0] SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] x,
    output logic             bit_out,
    output logic             wrap,
    output logic [31:0]      period,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? ONE : SEED_W;

    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] nxt;
    logic [31:0]      cnt;
    logic [31:0]      cnt_inc;

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_next (
        .x   (x),
        .nxt (nxt)
    );

    // Saturating so a stuck non-maximal sequence never reports a bogus short period.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
    assign bit_out = (MODE == MODE_FIB) ? x[WIDTH-1] : x[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= SEED_EFF;
            seed   <= SEED_EFF;
            cnt    <= '0;
            period <= '0;
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                cnt <= '0;
                if (seed_in == '0) begin
                    x      <= ONE;
                    seed   <= ONE;
                    lockup <= 1'b1;
                end else begin
                    x    <= seed_in;
                    seed <= seed_in;
                end
            end else if (en) begin
                if (x == '0) begin
                    x      <= seed;
                    cnt    <= '0;
                    lockup <= 1'b1;
                end else if (nxt == seed) begin
                    x      <= nxt;
                    cnt    <= '0;
                    period <= cnt_inc;
                    wrap   <= 1'b1;
                end else begin
                    x   <= nxt;
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: three 4-bit builds (Fibonacci, Galois, Galois with no taps)
// share one stimulus stream; a behavioural model predicts every cycle's outputs.
module tb_lfsr_prng;

    localparam int N = 3;

    typedef struct {
        logic [N-1:0][3:0]  x;
        logic [N-1:0]       b;
        logic [N-1:0]       wrap;
        logic [N-1:0]       lock;
        logic [N-1:0][31:0] per;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed_in = 4'd0;

    logic [3:0]  xs   [N];
    logic        bs   [N];
    logic        wrs  [N];
    logic        lks  [N];
    logic [31:0] pers [N];

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    // Model state: plain integers, advanced by the documented stepping rules.
    int mode_k [N] = '{0, 1, 1};
    int taps_k [N] = '{12, 12, 0};
    int mx [N];
    int mseed [N];
    int mcnt [N];
    int mper [N];

    logic [3:0] fib_seq [0:6] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD};
    logic [3:0] gal_seq [0:5] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA};

    always #5 clk = ~clk;

    lfsr_prng #(.WIDTH(4), .TAPS(32'hC), .MODE(0), .SEED(32'd1)) d0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .x(xs[0]), .bit_out(bs[0]), .wrap(wrs[0]), .period(pers[0]), .lockup(lks[0]));
    lfsr_prng #(.WIDTH(4), .TAPS(32'hC), .MODE(1), .SEED(32'd1)) d1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .x(xs[1]), .bit_out(bs[1]), .wrap(wrs[1]), .period(pers[1]), .lockup(lks[1]));
    lfsr_prng #(.WIDTH(4), .TAPS(32'h0), .MODE(1), .SEED(32'd1)) d2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .x(xs[2]), .bit_out(bs[2]), .wrap(wrs[2]), .period(pers[2]), .lockup(lks[2]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int model_next(input int k, input int v);
        int p;
        if (mode_k[k] == 0) begin
            p = $countones(v & taps_k[k]) % 2;
            return ((v * 2) + p) % 16;
        end
        return (v / 2) ^ (((v % 2) == 1) ? taps_k[k] : 0);
    endfunction

    // Drive one cycle of inputs at the falling edge and queue what the following rising edge must produce.
    task automatic cyc(input bit r, input bit l, input bit e, input logic [3:0] s);
        exp_t ex;
        int n;
        @(negedge clk);
        rst = r; load = l; en = e; seed_in = s;
        for (int k = 0; k < N; k++) begin
            ex.wrap[k] = 1'b0;
            ex.lock[k] = 1'b0;
            if (r) begin
                mx[k] = 1; mseed[k] = 1; mcnt[k] = 0; mper[k] = 0;
            end else if (l) begin
                mx[k] = (s == 0) ? 1 : int'(s);
                mseed[k] = mx[k];
                mcnt[k] = 0;
                ex.lock[k] = (s == 0);
            end else if (e) begin
                if (mx[k] == 0) begin
                    mx[k] = mseed[k]; mcnt[k] = 0; ex.lock[k] = 1'b1;
                end else begin
                    n = model_next(k, mx[k]);
                    if (n == mseed[k]) begin
                        mper[k] = mcnt[k] + 1; mcnt[k] = 0; ex.wrap[k] = 1'b1;
                    end else begin
                        mcnt[k] = mcnt[k] + 1;
                    end
                    mx[k] = n;
                end
            end
            ex.x[k]   = 4'(mx[k]);
            ex.b[k]   = (mode_k[k] == 0) ? ((mx[k] / 8) % 2 == 1) : (mx[k] % 2 == 1);
            ex.per[k] = 32'(mper[k]);
        end
        q.push_back(ex);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising edge with a pending expectation is compared once the outputs settle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < N; k++) begin
                    chk("x", k, 32'(xs[k]), 32'(e.x[k]));
                    chk("bit_out", k, 32'(bs[k]), 32'(e.b[k]));
                    chk("wrap", k, 32'(wrs[k]), 32'(e.wrap[k]));
                    chk("lockup", k, 32'(lks[k]), 32'(e.lock[k]));
                    chk("period", k, pers[k], e.per[k]);
                end
            end
        end
    end

    initial begin
        int guard;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        settle();
        for (int k = 0; k < N; k++) begin
            chk("rst_x", k, 32'(xs[k]), 32'd1);
            chk("rst_period", k, pers[k], 32'd0);
        end

        // Full cycle from reset: anchor against the published sequences.
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1, 0);
            settle();
            if (i < 7) chk("fib_seq", i, 32'(xs[0]), 32'(fib_seq[i]));
            if (i < 6) chk("gal_seq", i, 32'(xs[1]), 32'(gal_seq[i]));
            if (i == 14) chk("early_wrap", 0, 32'(wrs[0]), 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            chk("wrap15", k, 32'(wrs[k]), 32'd1);
            chk("period15", k, pers[k], 32'd15);
            chk("wrap_x", k, 32'(xs[k]), 32'd1);
        end

        // Enable with gaps: state and counter must hold through idle cycles.
        for (int i = 0; i < 45; i++) cyc(0, 0, (i % 3) != 1, 0);
        settle();
        chk("gap_period", 0, pers[0], 32'd15);

        // Load beats enable; then a full cycle back to the loaded seed.
        cyc(0, 1, 1, 4'h9);
        settle();
        chk("load_x", 0, 32'(xs[0]), 32'h9);
        chk("load_wrap", 0, 32'(wrs[0]), 32'd0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("seed9_x", k, 32'(xs[k]), 32'h9);
            chk("seed9_wrap", k, 32'(wrs[k]), 32'd1);
            chk("seed9_period", k, pers[k], 32'd15);
        end

        // Zero seed and a tap-less register falling into the all-zero state.
        cyc(0, 1, 0, 4'h0);
        settle();
        for (int k = 0; k < N; k++) begin
            chk("zero_load_x", k, 32'(xs[k]), 32'd1);
            chk("zero_load_lock", k, 32'(lks[k]), 32'd1);
        end
        cyc(0, 1, 0, 4'h8);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        settle();
        chk("drain_x", 2, 32'(xs[2]), 32'd0);
        cyc(0, 0, 1, 0);
        settle();
        chk("recover_x", 2, 32'(xs[2]), 32'h8);
        chk("recover_lock", 2, 32'(lks[2]), 32'd1);

        // Reset after a wrap clears everything, including period.
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);
        settle();
        for (int k = 0; k < N; k++) begin
            chk("rst_mid_x", k, 32'(xs[k]), 32'd1);
            chk("rst_mid_period", k, pers[k], 32'd0);
            chk("rst_mid_wrap", k, 32'(wrs[k]), 32'd0);
            chk("rst_mid_lock", k, 32'(lks[k]), 32'd0);
        end

        // Random traffic: mostly stepping, occasional loads (zero seeds included) and resets.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                4'($urandom_range(15)));
        cyc(0, 0, 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached=%0t limit=500000", $time);
        $fatal(1, "bench time limit");
    end

endmodule
